// File: rtl/conv_addr_sequencer.sv
// Convolution address sequencer: sweeps every filter tap of every stride-spaced
// window in raster order, emitting ifmap/filter read address pairs over valid/ready.
module conv_addr_sequencer #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DIM_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  img_w,
    input  logic [DIM_WIDTH-1:0]  img_h,
    input  logic [DIM_WIDTH-1:0]  flt_size,
    input  logic [DIM_WIDTH-1:0]  stride,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] ifmap_addr,
    output logic [ADDR_WIDTH-1:0] filt_addr,
    output logic                  last_tap,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned EW = DIM_WIDTH + 2;
    localparam int unsigned PW = 2 * DIM_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                r_state;
    logic [DIM_WIDTH-1:0]  r_w, r_h, r_f, r_s;
    logic [DIM_WIDTH-1:0]  r_kx, r_ky, r_ox, r_oy;
    logic [ADDR_WIDTH-1:0] r_row;
    logic [ADDR_WIDTH-1:0] r_win;
    logic [ADDR_WIDTH-1:0] r_sw;

    logic [DIM_WIDTH-1:0]  w_fm1;
    logic                  w_kx_end, w_ky_end, w_ox_more, w_oy_more;
    logic [EW-1:0]         w_ox_nxt, w_oy_nxt;
    logic                  w_illegal;
    logic [ADDR_WIDTH-1:0] w_sw;
    logic [ADDR_WIDTH-1:0] w_wa;
    logic                  w_xfer;

    logic [DIM_WIDTH-1:0]  w_kx_n, w_ky_n, w_ox_n, w_oy_n;
    logic [ADDR_WIDTH-1:0] w_row_n, w_win_n, w_ifm_n, w_flt_n;
    logic                  w_last_tap_n;
    logic                  w_last_xfer;

    assign w_fm1     = r_f - DIM_WIDTH'(1);
    assign w_kx_end  = (r_kx == w_fm1);
    assign w_ky_end  = (r_ky == w_fm1);
    assign w_ox_nxt  = EW'(r_ox) + EW'(r_s);
    assign w_oy_nxt  = EW'(r_oy) + EW'(r_s);
    assign w_ox_more = (w_ox_nxt + EW'(r_f)) <= EW'(r_w);
    assign w_oy_more = (w_oy_nxt + EW'(r_f)) <= EW'(r_h);
    assign w_wa      = ADDR_WIDTH'(r_w);
    assign w_xfer    = out_valid & out_ready;

    assign w_illegal = (flt_size == '0) || (stride == '0) ||
                       (flt_size > img_w) || (flt_size > img_h);
    // Row step for one window stride (S*W), computed once per sweep
    assign w_sw      = ADDR_WIDTH'(PW'(img_w) * PW'(stride));

    // Next loop indices and addresses for the pair after the current one
    always_comb begin
        w_kx_n      = r_kx;
        w_ky_n      = r_ky;
        w_ox_n      = r_ox;
        w_oy_n      = r_oy;
        w_row_n     = r_row;
        w_win_n     = r_win;
        w_ifm_n     = ifmap_addr;
        w_flt_n     = filt_addr;
        w_last_xfer = 1'b0;
        if (!w_kx_end) begin
            w_kx_n  = r_kx + DIM_WIDTH'(1);
            w_ifm_n = ifmap_addr + ADDR_WIDTH'(1);
            w_flt_n = filt_addr + ADDR_WIDTH'(1);
        end else if (!w_ky_end) begin
            w_kx_n  = '0;
            w_ky_n  = r_ky + DIM_WIDTH'(1);
            w_row_n = r_row + w_wa;
            w_ifm_n = r_row + w_wa + ADDR_WIDTH'(r_ox);
            w_flt_n = filt_addr + ADDR_WIDTH'(1);
        end else if (w_ox_more) begin
            w_kx_n  = '0;
            w_ky_n  = '0;
            w_ox_n  = DIM_WIDTH'(w_ox_nxt);
            w_row_n = r_win;
            w_ifm_n = r_win + ADDR_WIDTH'(w_ox_nxt);
            w_flt_n = '0;
        end else if (w_oy_more) begin
            w_kx_n  = '0;
            w_ky_n  = '0;
            w_ox_n  = '0;
            w_oy_n  = DIM_WIDTH'(w_oy_nxt);
            w_win_n = r_win + r_sw;
            w_row_n = r_win + r_sw;
            w_ifm_n = r_win + r_sw;
            w_flt_n = '0;
        end else begin
            w_last_xfer = 1'b1;
        end
    end

    assign w_last_tap_n = (w_kx_n == w_fm1) && (w_ky_n == w_fm1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_w        <= '0;
            r_h        <= '0;
            r_f        <= '0;
            r_s        <= '0;
            r_kx       <= '0;
            r_ky       <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_row      <= '0;
            r_win      <= '0;
            r_sw       <= '0;
            out_valid  <= 1'b0;
            ifmap_addr <= '0;
            filt_addr  <= '0;
            last_tap   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_w        <= img_w;
                        r_h        <= img_h;
                        r_f        <= flt_size;
                        r_s        <= stride;
                        r_sw       <= w_sw;
                        r_kx       <= '0;
                        r_ky       <= '0;
                        r_ox       <= '0;
                        r_oy       <= '0;
                        r_row      <= '0;
                        r_win      <= '0;
                        ifmap_addr <= '0;
                        filt_addr  <= '0;
                        busy       <= 1'b1;
                        err        <= w_illegal;
                        if (w_illegal) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state   <= S_RUN;
                            out_valid <= 1'b1;
                            last_tap  <= (flt_size == DIM_WIDTH'(1));
                        end
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        if (w_last_xfer) begin
                            r_state   <= S_DONE;
                            out_valid <= 1'b0;
                            last_tap  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            r_kx       <= w_kx_n;
                            r_ky       <= w_ky_n;
                            r_ox       <= w_ox_n;
                            r_oy       <= w_oy_n;
                            r_row      <= w_row_n;
                            r_win      <= w_win_n;
                            ifmap_addr <= w_ifm_n;
                            filt_addr  <= w_flt_n;
                            last_tap   <= w_last_tap_n;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_addr_sequencer.sv
// Scoreboard bench for conv_addr_sequencer: a loop-nest reference model queues
// expected address pairs, a negedge monitor pops and compares on each transfer.
module tb_conv_addr_sequencer;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 4;

    typedef struct packed {
        logic [AW-1:0] ifm;
        logic [AW-1:0] flt;
        logic          last;
    } pair_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [DW-1:0] img_w, img_h, flt_size, stride;
    logic          out_ready;
    logic          out_valid;
    logic [AW-1:0] ifmap_addr, filt_addr;
    logic          last_tap, busy, done, err;

    pair_t         sb[$];
    logic [AW-1:0] obs[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            c0 = 0;
    int            n_xfer = 0;
    int            n_last = 0;
    int            done_cnt = 0;
    int            stall_at = -1;
    int            stall_left = 0;

    conv_addr_sequencer #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .img_w      (img_w),
        .img_h      (img_h),
        .flt_size   (flt_size),
        .stride     (stride),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .ifmap_addr (ifmap_addr),
        .filt_addr  (filt_addr),
        .last_tap   (last_tap),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Backpressure driver: drops out_ready for stall_left cycles once stall_at pairs are done
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && n_xfer == stall_at) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (done) begin
                done_cnt++;
                check("valid_in_done", 32'(out_valid), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_xfer", 32'd1, 32'd0);
                end else begin
                    pair_t e;
                    e = sb.pop_front();
                    check("ifmap_addr", 32'(ifmap_addr), 32'(e.ifm));
                    check("filt_addr", 32'(filt_addr), 32'(e.flt));
                    check("last_tap", 32'(last_tap), 32'(e.last));
                end
                obs.push_back(ifmap_addr);
                n_xfer++;
                if (last_tap) n_last++;
            end else if (out_valid && sb.size() > 0) begin
                check("hold_ifmap", 32'(ifmap_addr), 32'(sb[0].ifm));
                check("hold_filt", 32'(filt_addr), 32'(sb[0].flt));
            end
        end
    end

    // Queue the reference sequence and pulse start for one sampled edge
    task automatic kick(input int w, input int h, input int f, input int s, input bit legal);
        pair_t p;
        sb.delete();
        obs.delete();
        n_xfer = 0;
        n_last = 0;
        if (legal) begin
            for (int oy = 0; oy + f <= h; oy += s)
                for (int ox = 0; ox + f <= w; ox += s)
                    for (int ky = 0; ky < f; ky++)
                        for (int kx = 0; kx < f; kx++) begin
                            p.ifm  = AW'(((oy + ky) * w + ox + kx) % (1 << AW));
                            p.flt  = AW'((ky * f + kx) % (1 << AW));
                            p.last = (ky == f - 1) && (kx == f - 1);
                            sb.push_back(p);
                        end
        end
        @(posedge clk);
        #1;
        img_w    = DW'(w);
        img_h    = DW'(h);
        flt_size = DW'(f);
        stride   = DW'(s);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0    = cyc;
        check("start_valid", 32'(out_valid), 32'(legal));
        if (legal) check("start_err_clear", 32'(err), 32'd0);
    endtask

    task automatic wait_done(input int exp_lat, input bit exp_err);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 300);
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_latency", 32'(cyc - c0), 32'(exp_lat));
            check("done_err", 32'(err), 32'(exp_err));
            check("done_busy", 32'(busy), 32'd1);
            check("sb_drained", 32'(sb.size()), 32'd0);
            @(negedge clk);
            check("done_clear", 32'(done), 32'd0);
            check("busy_clear", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int k;
        rstn = 1'b1;
        start = 1'b0;
        img_w = '0;
        img_h = '0;
        flt_size = '0;
        stride = '0;
        #2 rstn = 1'b0;
        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ifmap", 32'(ifmap_addr), 32'd0);
        check("rst_filt", 32'(filt_addr), 32'd0);
        check("rst_flags", 32'({last_tap, busy, done, err}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Basic sweep: 4x4 image, 3x3 filter, stride 1
        kick(4, 4, 3, 1, 1'b1);
        wait_done(36, 1'b0);
        check("t1_xfers", 32'(n_xfer), 32'd36);
        check("t1_last_cnt", 32'(n_last), 32'd4);
        check("t1_win3_origin", 32'(obs[27]), 32'd5);

        // Stride 2 windows
        kick(5, 5, 2, 2, 1'b1);
        wait_done(16, 1'b0);
        check("t2_xfers", 32'(n_xfer), 32'd16);
        check("t2_org0", 32'(obs[0]), 32'd0);
        check("t2_org1", 32'(obs[4]), 32'd2);
        check("t2_org2", 32'(obs[8]), 32'd10);
        check("t2_org3", 32'(obs[12]), 32'd12);
        check("t2_win1_last", 32'(obs[7]), 32'd8);

        // Backpressure at the fifth pair
        stall_at = 4;
        stall_left = 3;
        kick(4, 4, 3, 1, 1'b1);
        wait_done(39, 1'b0);
        check("t3_xfers", 32'(n_xfer), 32'd36);
        check("t3_after_stall", 32'(obs[5]), 32'd6);
        stall_at = -1;

        // Illegal configurations, then a legal start clears err
        kick(4, 4, 5, 1, 1'b0);
        wait_done(0, 1'b1);
        check("t4_err_held", 32'(err), 32'd1);
        kick(4, 4, 3, 0, 1'b0);
        wait_done(0, 1'b1);
        check("t4_no_xfer", 32'(n_xfer), 32'd0);
        kick(4, 4, 3, 1, 1'b1);
        wait_done(36, 1'b0);

        // Start pulsed mid-sweep with a different config is ignored
        kick(4, 4, 3, 1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        img_w = DW'(5);
        flt_size = DW'(2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(36, 1'b0);
        check("t5_xfers", 32'(n_xfer), 32'd36);

        // Asynchronous abort mid-sweep
        kick(4, 4, 3, 1, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ifmap", 32'(ifmap_addr), 32'd0);
        check("abort_filt", 32'(filt_addr), 32'd0);
        check("abort_flags", 32'({last_tap, busy, done}), 32'd0);
        k = done_cnt;
        sb.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(k));
        kick(5, 5, 2, 2, 1'b1);
        wait_done(16, 1'b0);
        check("restart_addr0", 32'(obs[0]), 32'd0);

        // Address wrap with 4-bit addresses
        kick(15, 15, 2, 13, 1'b1);
        wait_done(16, 1'b0);
        check("wrap_a0", 32'(obs[12]), 32'd0);
        check("wrap_a1", 32'(obs[13]), 32'd1);
        check("wrap_a2", 32'(obs[14]), 32'd15);
        check("wrap_a3", 32'(obs[15]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
